// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register for the transceiver serializer path.
// Optional occupancy status (bits_left/empty) is enabled by defining PISO_STATUS_EN.
module piso_shift_reg #(
   parameter int unsigned DATA_WIDTH = 9,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic        FILL_BIT   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:1] x,
   output logic [DATA_WIDTH-1:1] y,
   output logic                  z
`ifdef PISO_STATUS_EN
   ,
   output logic [$clog2(DATA_WIDTH):0] bits_left,
   output logic                        empty
`endif
);

   localparam int unsigned PAY_W = DATA_WIDTH - 1;

   logic [PAY_W-1:0] shift_val;

   // Next register contents on a shift edge; the vacated end takes FILL_BIT
   always_comb begin
      shift_val = y;
      if (MSB_FIRST) begin
         shift_val = {y[DATA_WIDTH-2:1], FILL_BIT};
      end else begin
         shift_val = {FILL_BIT, y[DATA_WIDTH-1:2]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y <= '0;
      end else if (load) begin
         y <= x;
      end else begin
         y <= shift_val;
      end
   end

   // Serial bit is taken straight from the register so it is valid the cycle after load
   assign z = MSB_FIRST ? y[DATA_WIDTH-1] : y[1];

`ifdef PISO_STATUS_EN
   localparam int unsigned    CNT_W   = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] PAYLOAD = CNT_W'(PAY_W);

   logic [CNT_W-1:0] cnt_next;

   // Counts the bit currently on z as still pending; saturates at zero
   always_comb begin
      cnt_next = bits_left;
      if (load) begin
         cnt_next = PAYLOAD;
      end else if (bits_left != '0) begin
         cnt_next = bits_left - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bits_left <= '0;
         empty     <= 1'b1;
      end else begin
         bits_left <= cnt_next;
         empty     <= (cnt_next == '0);
      end
   end
`endif

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg (DATA_WIDTH=9, MSB_FIRST=1, FILL_BIT=0).
// Status outputs are exercised when PISO_STATUS_EN is defined.
module tb_piso_shift_reg;

   localparam int unsigned DW = 9;
   localparam int unsigned PW = DW - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load;
   logic [PW-1:0] x;
   logic [PW-1:0] y;
   logic          z;
`ifdef PISO_STATUS_EN
   logic [$clog2(DW):0] bits_left;
   logic                empty;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          rst_n;
      logic          load;
      logic [PW-1:0] x;
      logic [PW-1:0] exp_y;
      logic          exp_z;
   } vec_t;

   typedef struct {
      logic [PW-1:0] y;
      logic          z;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   logic [PW-1:0] model_y;

   piso_shift_reg #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .x        (x),
      .y        (y),
      .z        (z)
`ifdef PISO_STATUS_EN
      ,
      .bits_left(bits_left),
      .empty    (empty)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one edge's inputs, queue the expectation, then compare just after the edge
   task automatic step(input logic r, input logic l, input logic [PW-1:0] xv,
                       input logic [PW-1:0] ey, input logic ez, input string name);
      exp_t e;
      @(negedge clk);
      rst_n = r;
      load  = l;
      x     = xv;
      e.y = ey;
      e.z = ez;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({name, "_y"}, 32'(y), 32'(e.y));
      check({name, "_z"}, 32'(z), 32'(e.z));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      load  = 1'b1;
      x     = '0;

      // Reset, capture, A5 walk-out, reset mid-shift, reload mid-shift
      vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h4A, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h94, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h28, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h50, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'hA0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h40, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h80, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'hFE, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'hFC, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'hF8, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 8'hF0, 8'hF0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'hE0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 8'hC0, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 8'h0F, 8'h0F, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 8'h3C, 8'h00, 1'b0});

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].load, vecs[i].x, vecs[i].exp_y, vecs[i].exp_z,
              $sformatf("vec%0d", i));
      end

      // Reset asserted between edges must not disturb y until the next edge
      step(1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, "preload");
      @(negedge clk);
      rst_n = 1'b0;
      load  = 1'b0;
      #2;
      check("async_rst_y", 32'(y), 32'h5A);
      @(posedge clk);
      #1;
      check("sync_rst_y", 32'(y), 32'h00);
      check("sync_rst_z", 32'(z), 32'h0);

      // Random load/shift/reset mix against a reference model
      model_y = '0;
      for (int n = 0; n < 60; n++) begin
         logic          r;
         logic          l;
         logic [PW-1:0] xv;
         r  = ($urandom_range(0, 15) != 0);
         l  = ($urandom_range(0, 3) == 0);
         xv = PW'($urandom);
         if (!r)      model_y = '0;
         else if (l)  model_y = xv;
         else         model_y = {model_y[PW-2:0], 1'b0};
         step(r, l, xv, model_y, model_y[PW-1], $sformatf("rnd%0d", n));
      end

`ifdef PISO_STATUS_EN
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "st_rst");
      check("st_rst_bits", 32'(bits_left), 32'd0);
      check("st_rst_empty", 32'(empty), 32'd1);
      step(1'b1, 1'b1, 8'hC3, 8'hC3, 1'b1, "st_load");
      check("st_load_bits", 32'(bits_left), 32'd8);
      check("st_load_empty", 32'(empty), 32'd0);
      model_y = 8'hC3;
      for (int k = 1; k <= 10; k++) begin
         model_y = {model_y[PW-2:0], 1'b0};
         step(1'b1, 1'b0, 8'h00, model_y, model_y[PW-1], $sformatf("st_sh%0d", k));
         check($sformatf("st_bits%0d", k), 32'(bits_left), (k >= 8) ? 32'd0 : 32'(8 - k));
         check($sformatf("st_empty%0d", k), 32'(empty), (k >= 8) ? 32'd1 : 32'd0);
      end
`endif

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
